// File: rtl/bcd2bin_seq_pkg.sv
// bcd_pkg: shared types and constants for the sequential BCD-to-binary
// converter.
//   state_e        - converter FSM states (IDLE, CONV, DONE)
//   BCD_DIGIT_W    - bits per BCD digit
//   BCD_MAX_DIGIT  - largest legal BCD digit value
//   bcd_bin_width  - ceil(log2(10^digits)), the BIN_W that holds every
//                    legal value of a digits-wide BCD word (digits <= 19)
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int         BCD_DIGIT_W   = 4;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   function automatic int bcd_bin_width(input int digits);
      logic [63:0] pow10;
      int          w;
      pow10 = 64'd1;
      for (int i = 0; i < digits && i < 19; i++) pow10 = pow10 * 64'd10;
      // smallest w with 2^w >= 10^digits
      w = 0;
      for (int b = 0; b < 64; b++) begin
         if ((64'd1 << b) < pow10) w = b + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: input/output handshakes of the BCD-to-binary converter.
//   in_valid/in_ready/in_bcd           - BCD word from the source
//   out_valid/out_ready/out_bin/out_err/out_ovf - result to the sink
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready. Once valid is raised, the sender holds valid and its
// data unchanged until that transfer; ready may change freely.
// master = source/sink side (testbench, datapath), slave = converter.
interface bcd2bin_seq_if #(
   parameter int DIGITS = 13,
   parameter int BIN_W  = 44
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_bcd;
   logic                  out_valid;
   logic                  out_ready;
   logic [BIN_W-1:0]      out_bin;
   logic                  out_err;
   logic                  out_ovf;

   modport master (
      output in_valid, in_bcd, out_ready,
      input  in_ready, out_valid, out_bin, out_err, out_ovf
   );

   modport slave (
      input  in_valid, in_bcd, out_ready,
      output in_ready, out_valid, out_bin, out_err, out_ovf
   );
endinterface

// File: rtl/bcd2bin_seq_mac10_step.sv
// bcd_mac10_step: one combinational conversion step, acc*10 + digit.
//   acc_i   - running binary accumulator (BIN_W bits)
//   digit_i - current BCD digit, raw value (may exceed 9)
//   acc_o   - low BIN_W bits of acc*10 + digit
//   ovf_o   - result needed more than BIN_W bits
// acc*10 is built from two shifts and an add; BIN_W+4 bits always hold
// acc*10 + 15, so the carry-out bits are exact.
module bcd_mac10_step
   import bcd_pkg::*;
#(
   parameter int BIN_W = 44
) (
   input  logic [BIN_W-1:0]       acc_i,
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BIN_W-1:0]       acc_o,
   output logic                   ovf_o
);
   localparam int WIDE_W = BIN_W + 4;

   logic [WIDE_W-1:0] acc_w;
   logic [WIDE_W-1:0] wide;

   assign acc_w = {4'b0000, acc_i};
   assign wide  = (acc_w << 3) + (acc_w << 1) + {{BIN_W{1'b0}}, digit_i};
   assign acc_o = wide[BIN_W-1:0];
   assign ovf_o = |wide[WIDE_W-1:BIN_W];
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter, one digit per clock,
// most significant digit first.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - slave side of bcd2bin_seq_if (input word, result)
//   dbg_state - current FSM state
// A word is accepted only in IDLE, converted over DIGITS cycles in CONV and
// presented in DONE until the sink takes it. The result registers load only
// on the CONV->DONE step, so they stay stable while a new word converts.
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 13,
   parameter int BIN_W  = 44
) (
   input  logic            clk,
   input  logic            rst_n,
   bcd2bin_seq_if.slave    bus,
   output state_e          dbg_state
);
   localparam int SH_W  = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_e            state_q, state_d;
   logic [SH_W-1:0]   sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIN_W-1:0]  acc_q, acc_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;
   logic [BIN_W-1:0]  out_bin_q, out_bin_d;
   logic              out_err_q, out_err_d;
   logic              out_ovf_q, out_ovf_d;

   logic [BCD_DIGIT_W-1:0] digit;
   logic                   digit_bad;
   logic [BIN_W-1:0]       step_acc;
   logic                   step_ovf;

   assign digit     = sh_q[SH_W-1 -: BCD_DIGIT_W];
   assign digit_bad = (digit > BCD_MAX_DIGIT);

   bcd_mac10_step #(.BIN_W(BIN_W)) u_step (
      .acc_i   (acc_q),
      .digit_i (digit),
      .acc_o   (step_acc),
      .ovf_o   (step_ovf)
   );

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      err_d     = err_q;
      ovf_d     = ovf_q;
      out_bin_d = out_bin_q;
      out_err_d = out_err_q;
      out_ovf_d = out_ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sh_d    = bus.in_bcd;
               cnt_d   = CNT_W'(DIGITS - 1);
               acc_d   = '0;
               err_d   = 1'b0;
               ovf_d   = 1'b0;
               state_d = CONV;
            end
         end
         CONV: begin
            // Out-of-range digits are flagged but still added raw so the
            // result stays a deterministic function of the input word.
            acc_d = step_acc;
            err_d = err_q | digit_bad;
            ovf_d = ovf_q | step_ovf;
            sh_d  = sh_q << BCD_DIGIT_W;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               out_bin_d = step_acc;
               out_err_d = err_q | digit_bad;
               out_ovf_d = ovf_q | step_ovf;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         out_bin_q <= '0;
         out_err_q <= 1'b0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         out_bin_q <= out_bin_d;
         out_err_q <= out_err_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_bin   = out_bin_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_ovf   = out_ovf_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: self-checking bench for bcd2bin_seq. Instance a is the
// full 13-digit/44-bit converter, instance b a 4-digit/8-bit one that
// overflows. Expected results are computed positionally (sum d_k*10^k).
module tb_bcd2bin_seq;
   import bcd_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd2bin_seq_if #(.DIGITS(13), .BIN_W(44)) a_if ();
   bcd2bin_seq_if #(.DIGITS(4),  .BIN_W(8))  b_if ();
   state_e a_state, b_state;

   bcd2bin_seq #(.DIGITS(13), .BIN_W(44)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if), .dbg_state(a_state));
   bcd2bin_seq #(.DIGITS(4), .BIN_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if), .dbg_state(b_state));

   // scoreboard: {err, ovf, bin[63:0]}
   logic [65:0] a_exp_q[$];
   logic [65:0] b_exp_q[$];
   int          a_lat_q[$];
   int          b_lat_q[$];
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [65:0] model(input logic [63:0] bcd, input int digits, input int bw);
      logic [63:0] v, p, mask;
      logic [3:0]  d;
      logic        e;
      v = 64'd0; p = 64'd1; e = 1'b0;
      for (int k = 0; k < digits; k++) begin
         d = bcd[4*k +: 4];
         if (d > 4'd9) e = 1'b1;
         v = v + 64'(d) * p;
         p = p * 64'd10;
      end
      mask = (64'd1 << bw) - 64'd1;
      return {e, ((v >> bw) != 64'd0), v & mask};
   endfunction

   // drivers: inputs change 1 time unit after the rising edge
   task automatic send_a(input logic [51:0] bcd);
      int g;
      @(posedge clk); #1;
      a_if.in_valid = 1'b1;
      a_if.in_bcd   = bcd;
      g = 0;
      @(negedge clk);
      while (!a_if.in_ready && g < 200) begin
         @(negedge clk); g++;
      end
      check("a_accept", 64'(a_if.in_ready), 64'd1);
      a_exp_q.push_back(model(64'(bcd), 13, 44));
      a_lat_q.push_back(cyc + 1);
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [15:0] bcd);
      int g;
      @(posedge clk); #1;
      b_if.in_valid = 1'b1;
      b_if.in_bcd   = bcd;
      g = 0;
      @(negedge clk);
      while (!b_if.in_ready && g < 200) begin
         @(negedge clk); g++;
      end
      check("b_accept", 64'(b_if.in_ready), 64'd1);
      b_exp_q.push_back(model(64'(bcd), 4, 8));
      b_lat_q.push_back(cyc + 1);
      @(posedge clk); #1;
      b_if.in_valid = 1'b0;
   endtask

   // monitors: sample on the falling edge
   logic a_prev_valid = 1'b0;
   logic b_prev_valid = 1'b0;
   always @(negedge clk) begin
      logic [65:0] e;
      int          t;
      if (!rst_n) begin
         a_prev_valid = 1'b0;
      end else begin
         if (a_if.out_valid && !a_prev_valid) begin
            if (a_lat_q.size() == 0) check("a_spurious_valid", 64'd1, 64'd0);
            else begin
               t = a_lat_q.pop_front();
               check("a_latency", 64'(cyc - t), 64'd13);
            end
         end
         if (a_if.out_valid && a_if.out_ready) begin
            if (a_exp_q.size() == 0) check("a_unexpected_out", 64'd1, 64'd0);
            else begin
               e = a_exp_q.pop_front();
               check("a_bin", 64'(a_if.out_bin), e[63:0]);
               check("a_err", 64'(a_if.out_err), 64'(e[65]));
               check("a_ovf", 64'(a_if.out_ovf), 64'(e[64]));
            end
         end
         a_prev_valid = a_if.out_valid;
      end
   end

   always @(negedge clk) begin
      logic [65:0] e;
      int          t;
      if (!rst_n) begin
         b_prev_valid = 1'b0;
      end else begin
         if (b_if.out_valid && !b_prev_valid) begin
            if (b_lat_q.size() == 0) check("b_spurious_valid", 64'd1, 64'd0);
            else begin
               t = b_lat_q.pop_front();
               check("b_latency", 64'(cyc - t), 64'd4);
            end
         end
         if (b_if.out_valid && b_if.out_ready) begin
            if (b_exp_q.size() == 0) check("b_unexpected_out", 64'd1, 64'd0);
            else begin
               e = b_exp_q.pop_front();
               check("b_bin", 64'(b_if.out_bin), e[63:0]);
               check("b_err", 64'(b_if.out_err), 64'(e[65]));
               check("b_ovf", 64'(b_if.out_ovf), 64'(e[64]));
            end
         end
         b_prev_valid = b_if.out_valid;
      end
   end

   task automatic drain_a();
      int g;
      g = 0;
      while (a_exp_q.size() != 0 && g < 100) begin
         @(negedge clk); g++;
      end
      check("a_drain", 64'(a_exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [51:0] w;
      logic [51:0] w2;
      logic [65:0] e1;
      int          g;
      int          stale;

      a_if.in_valid = 1'b0; a_if.in_bcd = '0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_bcd = '0; b_if.out_ready = 1'b1;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(a_if.in_ready), 64'd1);
      check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
      check("rst_out_bin",   64'(a_if.out_bin), 64'd0);
      check("rst_out_err",   64'(a_if.out_err), 64'd0);
      check("rst_out_ovf",   64'(a_if.out_ovf), 64'd0);
      check("rst_state",     64'(a_state), 64'(IDLE));
      rst_n = 1'b1;

      check("pkg_width_13", 64'(bcd_bin_width(13)), 64'd44);
      check("pkg_width_4",  64'(bcd_bin_width(4)),  64'd14);
      check("pkg_width_1",  64'(bcd_bin_width(1)),  64'd4);

      // directed words on the 13-digit converter
      send_a(52'h9999999999999);
      check("model_all9", model(64'h9999999999999, 13, 44), {2'b00, 64'h9184E729FFF});
      send_a(52'h0000000001234);
      send_a(52'h0000000000000);
      send_a(52'h000000000000A);
      send_a(52'h0000000000005);
      for (int n = 0; n < 6; n++) begin
         w = '0;
         for (int k = 0; k < 13; k++)
            w[4*k +: 4] = 4'($urandom_range(0, (n == 5) ? 15 : 9));
         send_a(w);
      end

      // overflow on the 4-digit/8-bit converter
      send_b(16'h0300);
      send_b(16'h0255);
      send_b(16'h0256);
      send_b(16'h9999);
      send_b(16'h00F0);
      drain_a();

      // backpressure: hold the result 5 cycles, next word waiting
      @(posedge clk); #1;
      a_if.out_ready = 1'b0;
      w  = 52'h0000000065535;
      w2 = 52'h0000000000789;
      e1 = model(64'(w), 13, 44);
      send_a(w);
      @(posedge clk); #1;
      a_if.in_valid = 1'b1;
      a_if.in_bcd   = w2;
      g = 0;
      @(negedge clk);
      while (!a_if.out_valid && g < 50) begin
         @(negedge clk); g++;
      end
      for (int s = 0; s < 5; s++) begin
         check("bp_out_valid", 64'(a_if.out_valid), 64'd1);
         check("bp_out_bin",   64'(a_if.out_bin), e1[63:0]);
         check("bp_in_ready",  64'(a_if.in_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_if.out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_at_hs", 64'(a_if.in_ready), 64'd0);
      @(negedge clk);
      check("bp_accept_next", 64'(a_if.in_ready), 64'd1);
      a_exp_q.push_back(model(64'(w2), 13, 44));
      a_lat_q.push_back(cyc + 1);
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      drain_a();

      // reset in the middle of a conversion
      send_a(52'h0000000000777);
      repeat (5) @(posedge clk);
      #1;
      check("mid_state", 64'(a_state), 64'(CONV));
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(a_if.out_valid), 64'd0);
      check("mid_rst_out_bin",   64'(a_if.out_bin), 64'd0);
      check("mid_rst_out_err",   64'(a_if.out_err), 64'd0);
      check("mid_rst_out_ovf",   64'(a_if.out_ovf), 64'd0);
      check("mid_rst_in_ready",  64'(a_if.in_ready), 64'd1);
      void'(a_exp_q.pop_back());
      void'(a_lat_q.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b1;
      stale = 0;
      for (int s = 0; s < 20; s++) begin
         @(negedge clk);
         if (a_if.out_valid) stale++;
      end
      check("post_rst_no_valid", 64'(stale), 64'd0);
      check("post_rst_in_ready", 64'(a_if.in_ready), 64'd1);
      send_a(52'h0000000000042);
      drain_a();

      g = 0;
      while (b_exp_q.size() != 0 && g < 50) begin
         @(negedge clk); g++;
      end
      check("b_drain", 64'(b_exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
